// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and default bit timing
package uart_pkg;

    // 2-bit FSM encodings shared by the receiver and transmitter
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // 100 MHz system clock at 9600 baud
    localparam int CLKS_PER_BIT_DEFAULT = 10416;

    // Last baud_cnt value of the half bit spent aligning to mid start bit
    function automatic logic [15:0] half_bit_last(input int clks_per_bit);
        return 16'(clks_per_bit / 2 - 1);
    endfunction

    // Last baud_cnt value of a full bit period
    function automatic logic [15:0] full_bit_last(input int clks_per_bit);
        return 16'(clks_per_bit - 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous 1-bit input
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; both come out of reset at the line idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_recv.sv
// rtl/uart_recv.sv - 8N1 UART receiver with mid-bit sampling and framing check
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] HALF_LAST = half_bit_last(CLKS_PER_BIT);
    localparam logic [15:0] FULL_LAST = full_bit_last(CLKS_PER_BIT);

    // Synchronized line and its previous value for falling-edge detection
    logic        w_din_s;
    logic        r_din_prev;

    uart_state_t r_state;
    uart_state_t w_state_nxt;
    logic [15:0] r_baud_cnt;
    logic [15:0] w_baud_nxt;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [7:0]  r_data;
    logic [7:0]  w_data_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        r_frame_err;
    logic        w_ferr_nxt;
    logic        w_fall;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (din),
        .o_q (w_din_s)
    );

    // A start is a 1->0 transition; a line held low never looks like one
    assign w_fall = r_din_prev & ~w_din_s;

    // Remember the synchronized line one cycle back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din_prev <= 1'b1;
        end else begin
            r_din_prev <= w_din_s;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_baud_cnt  <= 16'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_baud_cnt  <= w_baud_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
        end
    end

    // Next-state, bit timing, shifting and result pulses
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt + 16'd1;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_baud_nxt = 16'd0;
                if (w_fall) begin
                    w_state_nxt = START;
                end
            end

            // Wait half a bit so every later sample lands mid-bit
            START: begin
                if (r_baud_cnt == HALF_LAST) begin
                    w_baud_nxt = 16'd0;
                    w_bit_nxt  = 3'd0;
                    if (!w_din_s) begin
                        w_state_nxt = DATA;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            DATA: begin
                if (r_baud_cnt == FULL_LAST) begin
                    w_baud_nxt             = 16'd0;
                    w_shift_nxt[r_bit_cnt] = w_din_s;
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_nxt   = 3'd0;
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end

            // Only a high stop bit commits the byte to the output
            STOP: begin
                if (r_baud_cnt == FULL_LAST) begin
                    w_baud_nxt  = 16'd0;
                    w_state_nxt = IDLE;
                    if (w_din_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_baud_nxt  = 16'd0;
            end
        endcase
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// tb/tb_uart_recv.sv - scoreboard bench for uart_recv at 16 clocks per bit
`timescale 1ns/1ps
module tb_uart_recv;

    localparam int CPB = 16;

    typedef struct {
        bit         is_err;
        logic [7:0] d;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       din;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    exp_t       q[$];
    logic [7:0] exp_last;
    int         n_cmp;
    int         n_bad;
    int         n_valid;
    int         n_ferr;
    int         cyc;
    int         fall_cyc;
    int         valid_cyc;

    uart_recv #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pop one expectation per output pulse
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (valid || frame_err)) begin
            n_cmp++;
            if (valid && frame_err) begin
                n_bad++;
                $display("FAIL pulse_overlap: valid=%b frame_err=%b, required never both", valid, frame_err);
            end
            if (valid) begin
                n_valid++;
                valid_cyc = cyc;
            end
            if (frame_err) n_ferr++;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: valid=%b frame_err=%b data=%h, required no pulse", valid, frame_err, data);
            end else begin
                e = q.pop_front();
                if (frame_err !== e.is_err || data !== e.d) begin
                    n_bad++;
                    $display("FAIL sb_pulse: frame_err=%b data=%h, required frame_err=%b data=%h",
                             frame_err, data, e.is_err, e.d);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transmitter model: start, 8 data bits LSB first, stop; CPB cycles each
    task automatic send_byte(input logic [7:0] b, input logic stop);
        exp_t e;
        if (stop) begin
            e.is_err = 1'b0;
            e.d      = b;
            exp_last = b;
        end else begin
            e.is_err = 1'b1;
            e.d      = exp_last;
        end
        q.push_back(e);
        @(posedge clk); #1 din = 1'b0;
        fall_cyc = cyc;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1 din = b[i];
            repeat (CPB - 1) @(posedge clk);
        end
        @(posedge clk); #1 din = stop;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic check_quiet(input string name, input int v0, input int f0, input int dv, input int df);
        n_cmp++;
        if (n_valid - v0 !== dv) begin
            n_bad++;
            $display("FAIL %s_valid_count: got %0d, required %0d", name, n_valid - v0, dv);
        end
        n_cmp++;
        if (n_ferr - f0 !== df) begin
            n_bad++;
            $display("FAIL %s_ferr_count: got %0d, required %0d", name, n_ferr - f0, df);
        end
        n_cmp++;
        if (data !== exp_last) begin
            n_bad++;
            $display("FAIL %s_data: got %h, required %h", name, data, exp_last);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_busy: got %b, required 0", name, busy);
        end
        n_cmp++;
        if (q.size() !== 0) begin
            n_bad++;
            $display("FAIL %s_pending: got %0d outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b1;
        wait_cycles(3);
        @(negedge clk);
        n_cmp++;
        if ({data, valid, frame_err, busy} !== 11'h000) begin
            n_bad++;
            $display("FAIL reset_outputs: data=%h valid=%b frame_err=%b busy=%b, required 00 0 0 0",
                     data, valid, frame_err, busy);
        end
        @(posedge clk); #1 rst = 1'b0;
        wait_cycles(5);
        check_quiet("reset_idle", n_valid, n_ferr, 0, 0);
    endtask

    task automatic test_loopback();
        int v0 = n_valid;
        int f0 = n_ferr;
        send_byte(8'hA5, 1'b1);
        wait_cycles(4);
        check_quiet("loopback_a5", v0, f0, 1, 0);
    endtask

    task automatic test_glitch();
        int v0 = n_valid;
        int f0 = n_ferr;
        @(posedge clk); #1 din = 1'b0;
        wait_cycles(4);
        din = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_busy_start: got %b, required 1", busy);
        end
        wait_cycles(3 * CPB);
        check_quiet("glitch", v0, f0, 0, 0);
    endtask

    task automatic test_frame_err();
        int v0 = n_valid;
        int f0 = n_ferr;
        send_byte(8'h3C, 1'b0);
        wait_cycles(200);
        check_quiet("frame_err_held_low", v0, f0, 0, 1);
        din = 1'b1;
        wait_cycles(2 * CPB);
        check_quiet("frame_err_release", v0, f0, 0, 1);
    endtask

    task automatic test_reset_mid_frame();
        int v0 = n_valid;
        int f0 = n_ferr;
        @(posedge clk); #1 din = 1'b0;
        wait_cycles(CPB);
        din = 1'b1;
        wait_cycles(3 * CPB + CPB / 2);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midframe_busy: got %b, required 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({data, valid, frame_err, busy} !== 11'h000) begin
            n_bad++;
            $display("FAIL midframe_reset_outputs: data=%h valid=%b frame_err=%b busy=%b, required 00 0 0 0",
                     data, valid, frame_err, busy);
        end
        exp_last = 8'h00;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(6 * CPB);
        check_quiet("midframe_abort", v0, f0, 0, 0);
        send_byte(8'h5A, 1'b1);
        wait_cycles(4);
        check_quiet("after_reset_5a", v0, f0, 1, 0);
    endtask

    task automatic test_back_to_back();
        int v0 = n_valid;
        int f0 = n_ferr;
        logic [7:0] first_seen;
        send_byte(8'h00, 1'b1);
        first_seen = data;
        n_cmp++;
        if (first_seen !== 8'h00 || n_valid - v0 !== 1) begin
            n_bad++;
            $display("FAIL b2b_first: data=%h pulses=%0d, required data=00 pulses=1", first_seen, n_valid - v0);
        end
        send_byte(8'hFF, 1'b1);
        wait_cycles(4);
        check_quiet("b2b_second", v0, f0, 2, 0);
    endtask

    task automatic test_latency();
        int v0 = n_valid;
        int f0 = n_ferr;
        int lat;
        send_byte(8'h81, 1'b1);
        wait_cycles(4);
        check_quiet("latency_81", v0, f0, 1, 0);
        lat = valid_cyc - fall_cyc;
        n_cmp++;
        if (lat < 2 + CPB / 2 + 9 * CPB - 1 || lat > 2 + CPB / 2 + 9 * CPB + 1) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles, required %0d +/-1", lat, 2 + CPB / 2 + 9 * CPB);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        n_valid   = 0;
        n_ferr    = 0;
        cyc       = 0;
        fall_cyc  = 0;
        valid_cyc = 0;
        exp_last  = 8'h00;
        rst       = 1'b1;
        din       = 1'b1;
        test_reset();
        test_loopback();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_back_to_back();
        test_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
